// File: rtl/poly_packer_if.sv
// Bus bundle for poly_packer: start/config handshake, poly RAM read port and
// byte RAM write port. The packer uses the slave modport, its controller the master.
interface poly_packer_if #(
   parameter int POLY_ADDR_W = 10,
   parameter int BYTE_ADDR_W = 11
);
   logic                   start;
   logic                   mode;
   logic [BYTE_ADDR_W-1:0] out_base;
   logic                   busy;
   logic                   done;
   logic [POLY_ADDR_W-1:0] poly_addr;
   logic [15:0]            poly_doa;
   logic                   byte_we;
   logic [BYTE_ADDR_W-1:0] byte_addr;
   logic [7:0]             byte_di;

   modport master (
      output start, mode, out_base, poly_doa,
      input  busy, done, poly_addr, byte_we, byte_addr, byte_di
   );

   modport slave (
      input  start, mode, out_base, poly_doa,
      output busy, done, poly_addr, byte_we, byte_addr, byte_di
   );
endinterface

// File: rtl/poly_packer.sv
// Reduces N poly RAM coefficients mod 12289 and packs them LSB-first into the byte RAM.
// Define POLY_PACKER_COMPRESS_EN to build the 3-bit compress mode (mode = 1).
module poly_packer #(
   parameter int N           = 1024,
   parameter int POLY_ADDR_W = $clog2(N),
   parameter int BYTE_ADDR_W = 11
) (
   input logic          clk,
   input logic          rst_n,
   poly_packer_if.slave bus
);
   localparam int CNT_W = POLY_ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] ALL_IDX  = CNT_W'(N);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, REDUCE, EMIT, DONE} state_t;
   state_t state, next_state;

   logic [CNT_W-1:0]       coef_cnt;
   logic [BYTE_ADDR_W-1:0] byte_off;
   logic [BYTE_ADDR_W-1:0] base_q;
   logic [15:0]            data_q;
   logic [20:0]            acc;
   logic [4:0]             bit_cnt;

   logic [13:0] r;
   logic [13:0] field_v;
   logic [4:0]  field_w;
   logic [4:0]  sum_cnt;
   logic [20:0] appended;

   logic                   busy_nxt, done_nxt, we_nxt;
   logic [BYTE_ADDR_W-1:0] addr_nxt;
   logic [7:0]             di_nxt;

   // Input is below 5*12289 + 12289, so at most five subtractions are ever needed.
   always_comb begin
      if      (data_q >= 16'd61445) r = 14'(data_q - 16'd61445);
      else if (data_q >= 16'd49156) r = 14'(data_q - 16'd49156);
      else if (data_q >= 16'd36867) r = 14'(data_q - 16'd36867);
      else if (data_q >= 16'd24578) r = 14'(data_q - 16'd24578);
      else if (data_q >= 16'd12289) r = 14'(data_q - 16'd12289);
      else                          r = 14'(data_q);
   end

`ifdef POLY_PACKER_COMPRESS_EN
   logic        mode_q;
   logic [16:0] scaled;
   logic [2:0]  comp_v;

   // Rounded 8r/q; a quotient of 8 wraps to 0 through the 3-bit truncation.
   always_comb begin
      scaled = {r, 3'b000} + 17'd6144;
      comp_v = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         if (scaled >= 17'(k * 12289)) comp_v = 3'(k);
      end
   end

   always_comb begin
      if (mode_q) begin
         field_v = {11'd0, comp_v};
         field_w = 5'd3;
      end else begin
         field_v = r;
         field_w = 5'd14;
      end
   end
`else
   always_comb begin
      field_v = r;
      field_w = 5'd14;
   end
`endif

   assign sum_cnt       = bit_cnt + field_w;
   assign appended      = acc | (21'(field_v) << bit_cnt);
   assign bus.poly_addr = coef_cnt[POLY_ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // EMIT keeps draining while a second full byte will remain after this one.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = FETCH;
         FETCH:   next_state = WAIT;
         WAIT:    next_state = REDUCE;
         REDUCE: begin
            if (sum_cnt >= 5'd8)          next_state = EMIT;
            else if (coef_cnt != LAST_IDX) next_state = FETCH;
            else                           next_state = DONE;
         end
         EMIT: begin
            if (bit_cnt >= 5'd16)         next_state = EMIT;
            else if (coef_cnt != ALL_IDX) next_state = FETCH;
            else                          next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      we_nxt   = 1'b0;
      addr_nxt = '0;
      di_nxt   = '0;
      case (state)
         IDLE:                busy_nxt = bus.start;
         FETCH, WAIT, REDUCE: busy_nxt = 1'b1;
         EMIT: begin
            busy_nxt = 1'b1;
            we_nxt   = 1'b1;
            addr_nxt = base_q + byte_off;
            di_nxt   = acc[7:0];
         end
         DONE:                done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.byte_we   <= 1'b0;
         bus.byte_addr <= '0;
         bus.byte_di   <= '0;
      end else begin
         bus.busy      <= busy_nxt;
         bus.done      <= done_nxt;
         bus.byte_we   <= we_nxt;
         bus.byte_addr <= addr_nxt;
         bus.byte_di   <= di_nxt;
      end
   end

   // Run context is captured only on an accepted start, so mid-run input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef POLY_PACKER_COMPRESS_EN
         mode_q   <= 1'b0;
`endif
         base_q   <= '0;
         coef_cnt <= '0;
         byte_off <= '0;
         data_q   <= '0;
         acc      <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
`ifdef POLY_PACKER_COMPRESS_EN
                  mode_q   <= bus.mode;
`endif
                  base_q   <= bus.out_base;
                  coef_cnt <= '0;
                  byte_off <= '0;
                  acc      <= '0;
                  bit_cnt  <= '0;
               end
            end
            WAIT:   data_q <= bus.poly_doa;
            REDUCE: begin
               acc      <= appended;
               bit_cnt  <= sum_cnt;
               coef_cnt <= coef_cnt + CNT_W'(1);
            end
            EMIT: begin
               acc      <= acc >> 8;
               bit_cnt  <= bit_cnt - 5'd8;
               byte_off <= byte_off + BYTE_ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_poly_packer.sv
// Self-checking bench for poly_packer (N = 1024): a reference packer fills a write
// scoreboard before each run and every byte RAM write is popped and compared.
module tb_poly_packer;
   localparam int N   = 1024;
   localparam int PAW = 10;
   localparam int BAW = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   poly_packer_if #(.POLY_ADDR_W(PAW), .BYTE_ADDR_W(BAW)) bus ();

   poly_packer #(.N(N), .POLY_ADDR_W(PAW), .BYTE_ADDR_W(BAW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] poly_mem [N];
   always @(posedge clk) bus.poly_doa <= poly_mem[bus.poly_addr];

   int          errors = 0;
   int          checks = 0;
   logic [18:0] sb_q [$];
   int          wr_seen;
   logic [7:0]  first_bytes [3];
   logic [10:0] last_addr;
   int          run_cyc, run_bytes;
   int          exp_c_bytes, exp_c_cyc;
   logic [7:0]  exp_c0, exp_c1, exp_c2;
   int          guard;
   bit          done_flag;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic eff_mode(input logic m);
`ifdef POLY_PACKER_COMPRESS_EN
      return m;
`else
      return 1'b0 & m;
`endif
   endfunction

   // Reference packer working directly from the arithmetic definition of the fields.
   function automatic void build_expect(input logic emode, input logic [BAW-1:0] base,
                                        output int nbytes);
      longint acc = 0;
      int     cnt = 0;
      int     off = 0;
      int     r, v, w;
      for (int i = 0; i < N; i++) begin
         r = int'(poly_mem[i]) % 12289;
         if (emode) begin
            v = ((8 * r + 6144) / 12289) % 8;
            w = 3;
         end else begin
            v = r;
            w = 14;
         end
         acc = acc | (longint'(v) << cnt);
         cnt += w;
         while (cnt >= 8) begin
            sb_q.push_back({base + BAW'(off), 8'(acc & 255)});
            acc = acc >> 8;
            cnt -= 8;
            off++;
         end
      end
      nbytes = off;
   endfunction

   task automatic check_output();
      logic [31:0] exp_w;
      if (bus.byte_we === 1'b1) begin
         check("write_inside_busy", 32'(bus.busy), 32'd1);
         if (sb_q.size() != 0) exp_w = {13'd0, sb_q.pop_front()};
         else                  exp_w = 'x;
         check("write_addr_data", {13'd0, bus.byte_addr, bus.byte_di}, exp_w);
         if (wr_seen < 3) first_bytes[wr_seen] = bus.byte_di;
         last_addr = bus.byte_addr;
         wr_seen++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_output();
   endtask

   // One full run from start to done; cyc+1 is the edge that samples the done pulse.
   task automatic apply_stimulus(input logic m, input logic [BAW-1:0] base, input bit disturb,
                                 output int cyc, output int nbytes);
      build_expect(eff_mode(m), base, nbytes);
      wr_seen     = 0;
      bus.start    = 1'b1;
      bus.mode     = m;
      bus.out_base = base;
      tick();
      check("busy_after_start", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 6000) begin
         if (disturb) begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.mode     = 1'($urandom_range(0, 1));
            bus.out_base = BAW'($urandom_range(0, 2047));
         end
         tick();
         cyc++;
      end
      bus.start    = 1'b0;
      bus.mode     = m;
      bus.out_base = base;
      cyc = cyc + 1;
      check("done_seen", 32'(bus.done), 32'd1);
      check("busy_low_at_done", 32'(bus.busy), 32'd0);
      check("done_cycles", 32'(cyc), 32'(3 * N + nbytes + 2));
      check("write_count", 32'(wr_seen), 32'(nbytes));
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      tick();
      check("done_one_cycle", 32'(bus.done), 32'd0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.mode     = 1'b0;
      bus.out_base = '0;
      for (int i = 0; i < N; i++) poly_mem[i] = 16'(i);

`ifdef POLY_PACKER_COMPRESS_EN
      exp_c_bytes = 384;  exp_c_cyc = 3458;
      exp_c0 = 8'h41; exp_c1 = 8'h10; exp_c2 = 8'h04;
`else
      exp_c_bytes = 1792; exp_c_cyc = 4866;
      exp_c0 = 8'h00; exp_c1 = 8'h06; exp_c2 = 8'h00;
`endif

      tick();
      tick();
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_byte_we", 32'(bus.byte_we), 32'd0);
      check("reset_byte_addr", 32'(bus.byte_addr), 32'd0);
      check("reset_byte_di", 32'(bus.byte_di), 32'd0);
      check("reset_poly_addr", 32'(bus.poly_addr), 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] ramp pattern, 14-bit encode");
      apply_stimulus(1'b0, 11'd0, 1'b0, run_cyc, run_bytes);
      check("ramp_byte0", 32'(first_bytes[0]), 32'h00);
      check("ramp_byte1", 32'(first_bytes[1]), 32'h40);
      check("ramp_byte2", 32'(first_bytes[2]), 32'h00);
      check("ramp_cycles", 32'(run_cyc), 32'd4866);

      $display("[TB] all-ones pattern, base 100");
      for (int i = 0; i < N; i++) poly_mem[i] = 16'hFFFF;
      apply_stimulus(1'b0, 11'd100, 1'b0, run_cyc, run_bytes);
      check("ones_writes", 32'(wr_seen), 32'd1792);
      check("ones_last_addr", 32'(last_addr), 32'd1891);

      $display("[TB] q-1 pattern, mode 1");
      for (int i = 0; i < N; i++) poly_mem[i] = 16'd12288;
      apply_stimulus(1'b1, 11'd0, 1'b0, run_cyc, run_bytes);

      $display("[TB] alternating 1536/0 pattern, mode 1");
      for (int i = 0; i < N; i++) poly_mem[i] = (i % 2 == 0) ? 16'd1536 : 16'd0;
      apply_stimulus(1'b1, 11'd0, 1'b0, run_cyc, run_bytes);
      check("alt_byte0", 32'(first_bytes[0]), 32'(exp_c0));
      check("alt_byte1", 32'(first_bytes[1]), 32'(exp_c1));
      check("alt_byte2", 32'(first_bytes[2]), 32'(exp_c2));
      check("alt_writes", 32'(wr_seen), 32'(exp_c_bytes));
      check("alt_cycles", 32'(run_cyc), 32'(exp_c_cyc));

      $display("[TB] random data with start/mode/base toggling mid-run");
      for (int i = 0; i < N; i++) poly_mem[i] = 16'($urandom_range(0, 65535));
      apply_stimulus(1'b0, 11'd37, 1'b1, run_cyc, run_bytes);
      apply_stimulus(1'b1, 11'd500, 1'b1, run_cyc, run_bytes);

      $display("[TB] back-to-back start after done");
      apply_stimulus(1'b0, 11'd7, 1'b0, run_cyc, run_bytes);

      $display("[TB] reset abort mid-run");
      build_expect(1'b0, 11'd0, run_bytes);
      wr_seen      = 0;
      bus.start    = 1'b1;
      bus.mode     = 1'b0;
      bus.out_base = '0;
      tick();
      bus.start = 1'b0;
      guard = 0;
      while (wr_seen < 50 && guard < 2000) begin
         tick();
         guard++;
      end
      check("abort_point_reached", 32'(wr_seen), 32'd50);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_byte_we", 32'(bus.byte_we), 32'd0);
      check("abort_byte_addr", 32'(bus.byte_addr), 32'd0);
      check("abort_byte_di", 32'(bus.byte_di), 32'd0);
      check("abort_poly_addr", 32'(bus.poly_addr), 32'd0);
      sb_q.delete();
      done_flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.done === 1'b1) done_flag = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.done === 1'b1) done_flag = 1'b1;
      end
      check("abort_no_done", 32'(done_flag), 32'd0);
      apply_stimulus(1'b0, 11'd0, 1'b0, run_cyc, run_bytes);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
